// File: rtl/hex_sseg_scan_disp.sv
// Time-multiplexed 7-segment scan driver: hex decode, dp, sign digit, anti-ghost blanking.
// Latency: an/sseg are registered one cycle behind prescaler/slot; frame_done/commit_ack decode current state.
// Backpressure: none; load may arrive any cycle, last load before a frame boundary wins.
// Optional build macro HEX_SSEG_LZ_BLANK_EN adds leading-zero suppression computed at commit time.
module hex_sseg_scan_disp #(
  parameter int NUM_DIGITS   = 8,
  parameter int PRESC_W      = 15,
  parameter int BLANK_CYCLES = 16,
  parameter int SIGN_DIGIT   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    sign_in,
  output logic [7:0]              sseg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    commit_ack
);

  localparam int SLOT_W  = $clog2(NUM_DIGITS);
  localparam bit SIGN_EN = (SIGN_DIGIT < NUM_DIGITS);

  logic [PRESC_W-1:0]      prescaler_q, prescaler_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_sign_q, pend_sign_d;
  logic [4*NUM_DIGITS-1:0] cur_digits_q, cur_digits_d;
  logic [NUM_DIGITS-1:0]   cur_dp_q, cur_dp_d;
  logic                    cur_sign_q, cur_sign_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              sseg_q, sseg_d;

  logic presc_wrap, slot_last, boundary, commit;
  logic [3:0] nibble;
  logic       digit_blank;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign presc_wrap = (prescaler_q == {PRESC_W{1'b1}});
  assign slot_last  = (slot_q == SLOT_W'(NUM_DIGITS - 1));
  assign boundary   = presc_wrap && slot_last;
  assign commit     = boundary && pend_vld_q;
  assign frame_done = boundary;
  assign commit_ack = commit;
  assign nibble     = cur_digits_q[{slot_q, 2'b00} +: 4];

`ifdef HEX_SSEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_q, blank_d, lz_mask;
  logic                  seen_nz;

  // Leading-zero mask of the pending contents, scanning from the top digit down.
  always_comb begin
    lz_mask = '0;
    seen_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (i != SIGN_DIGIT) begin
        if (pend_digits_q[4*i +: 4] != 4'h0) seen_nz = 1'b1;
        lz_mask[i] = ~seen_nz;
      end
    end
    blank_d = commit ? lz_mask : blank_q;
  end

  // Mask travels with the committed data so it is stable for a whole frame.
  always_ff @(posedge clk) begin
    if (!rst_n) blank_q <= '0;
    else        blank_q <= blank_d;
  end

  assign digit_blank = blank_q[slot_q];
`else
  assign digit_blank = 1'b0;
`endif

  // Scan counters, pending/committed buffers and next registered display outputs.
  always_comb begin
    prescaler_d   = prescaler_q + 1'b1;
    slot_d        = slot_q;
    pend_vld_d    = pend_vld_q;
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_sign_d   = pend_sign_q;
    cur_digits_d  = cur_digits_q;
    cur_dp_d      = cur_dp_q;
    cur_sign_d    = cur_sign_q;
    an_d          = {NUM_DIGITS{1'b1}};
    sseg_d        = 8'hFF;

    if (presc_wrap) slot_d = slot_last ? '0 : slot_q + 1'b1;

    // Commit the old pending data first; a coincident load becomes the next pending.
    if (commit) begin
      cur_digits_d = pend_digits_q;
      cur_dp_d     = pend_dp_q;
      cur_sign_d   = pend_sign_q;
    end
    if (load) begin
      pend_vld_d    = 1'b1;
      pend_digits_d = digits_in;
      pend_dp_d     = dp_in;
      pend_sign_d   = sign_in;
    end else if (boundary) begin
      pend_vld_d = 1'b0;
    end

    // Outside the anti-ghost window drive exactly one anode.
    if (prescaler_q >= PRESC_W'(BLANK_CYCLES)) begin
      an_d = ~(NUM_DIGITS'(1) << slot_q);
      if (SIGN_EN && (int'(slot_q) == SIGN_DIGIT)) sseg_d[6:0] = cur_sign_q ? 7'h3F : 7'h7F;
      else if (digit_blank)                       sseg_d[6:0] = 7'h7F;
      else                                        sseg_d[6:0] = hex_decode(nibble);
      sseg_d[7] = ~cur_dp_q[slot_q];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler_q   <= '0;
      slot_q        <= '0;
      pend_vld_q    <= 1'b0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_sign_q   <= 1'b0;
      cur_digits_q  <= '0;
      cur_dp_q      <= '0;
      cur_sign_q    <= 1'b0;
      an_q          <= {NUM_DIGITS{1'b1}};
      sseg_q        <= 8'hFF;
    end else begin
      prescaler_q   <= prescaler_d;
      slot_q        <= slot_d;
      pend_vld_q    <= pend_vld_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_sign_q   <= pend_sign_d;
      cur_digits_q  <= cur_digits_d;
      cur_dp_q      <= cur_dp_d;
      cur_sign_q    <= cur_sign_d;
      an_q          <= an_d;
      sseg_q        <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: doc/hex_sseg_scan_disp.md
Name: hex_sseg_scan_disp

Overview:
- Parametrised, time-multiplexed seven-segment scan driver for NUM_DIGITS common-anode digits. Active-low segments and anodes.
- Per-digit hex decode, decimal point, optional sign digit, and anti-ghosting blanking at each digit change.
- Double-buffered input: a load pulse captures new contents, which are committed only at a frame boundary (no tearing).
- Sits between arithmetic/BCD datapaths and the board display pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..8; need not be a power of two).
- PRESC_W, 15, prescaler width; each digit slot lasts 2^PRESC_W clk cycles.
- BLANK_CYCLES, 16, cycles at the start of every slot with all anodes off; must be < 2^PRESC_W.
- SIGN_DIGIT, 2, index of the digit showing the sign; its nibble is ignored. A value of NUM_DIGITS disables the sign digit.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset: synchronous, active-low.
- load, in, 1, single-cycle pulse; captures digits_in, dp_in and sign_in into the pending buffer.
- digits_in, in, 4*NUM_DIGITS, nibble i drives digit i (digit 0 is rightmost).
- dp_in, in, NUM_DIGITS, decimal point request per digit; 1 = lit.
- sign_in, in, 1, 1 = show minus on SIGN_DIGIT.
- sseg, out, 8, segments; bits [6:0] are g..a, bit 7 is dp; all active-low.
- an, out, NUM_DIGITS, anode enables, active-low.
- frame_done, out, 1, one-cycle pulse on the last cycle of the slot for digit NUM_DIGITS-1.
- commit_ack, out, 1, one-cycle pulse in the cycle the pending buffer is committed.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - prescaler=0, slot=0, pending_valid=0.
  - Committed and pending digits, dp and sign all 0.
  - an=all ones, sseg=8'hFF, frame_done=0, commit_ack=0.
- Prescaler:
  - Increments every cycle; wraps at 2^PRESC_W-1 to 0.
  - On wrap, slot increments and wraps from NUM_DIGITS-1 to 0.
- Frame boundary = prescaler wrap while slot==NUM_DIGITS-1. In that cycle frame_done=1.
- Load:
  - load=1 writes the pending buffer and sets pending_valid.
  - A second load before commit overwrites the pending data; last load wins.
- Commit:
  - At a frame boundary with pending_valid=1: committed<=pending, pending_valid<=0, commit_ack=1 in that same cycle.
  - New contents are shown starting at slot 0 of the next frame.
- Load coinciding with a frame boundary:
  - The boundary commits the old pending data, if any.
  - The new load becomes pending and is committed at the following boundary.
  - If nothing was pending, the load is not committed until the next boundary.
- Outputs are registered, with one cycle of latency from prescaler/slot state to an/sseg.
- Blanking window: while prescaler < BLANK_CYCLES, an=all ones and sseg=8'hFF.
- Otherwise:
  - an has only bit [slot] low.
  - Non-sign digit: sseg[6:0] is the hex decode of the committed nibble. Codes 0..F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
  - Sign digit: sseg[6:0] = 7'h3F (minus) if sign=1, else 7'h7F (blank).
  - sseg[7] = ~dp[slot]; this applies on the sign digit too.
- Reset asserted mid-frame: all state returns to reset values on the next edge. The pending load is discarded.
- Inputs are sampled only when load=1; digits_in may change freely otherwise.

Optional Feature:
- Macro: HEX_SSEG_LZ_BLANK_EN.
- Defined: leading-zero suppression at commit time.
  - Scanning from digit NUM_DIGITS-1 downward (skipping SIGN_DIGIT), zero nibbles are blanked (sseg[6:0]=7'h7F) until the first nonzero nibble.
  - Digit 0 is never blanked.
  - DP still shows on blanked digits.
  - The blank mask is registered with the committed data and is stable for the whole frame.
- Undefined: every non-sign digit is decoded, including leading zeros. No mask logic is built.

Test Plan:
- Reset release, NUM_DIGITS=4, PRESC_W=3, BLANK_CYCLES=2, no load:
  - an sequence, 8-cycle slots each, is 1111,1111,1110x6, then 1111x2,1101x6, and so on.
  - sseg=8'hC0 on active non-sign digits, 8'hFF on digit 2 (sign 0).
  - frame_done is high once per 32 cycles.
- Load digits_in=16'h1A3F, dp_in=4'b0001, sign_in=1 mid-frame:
  - Display is unchanged until the boundary, then commit_ack pulses.
  - Next frame shows digit0=8'h0E (F, dp lit → bit7=0), digit1=8'hB0, digit2=8'hBF (minus), digit3=8'hF9.
- Two loads (16'h1111, then 16'h2222) before one boundary: only 16'h2222 is committed; exactly one commit_ack.
- load asserted in the frame_done cycle with nothing pending: no commit_ack that cycle; data commits at the next boundary.
- rst_n low for 1 cycle mid-slot with a pending load:
  - an=all ones and sseg=8'hFF the next cycle.
  - The pending load is discarded and no commit_ack follows.
- HEX_SSEG_LZ_BLANK_EN defined, NUM_DIGITS=4, SIGN_DIGIT=4, load 16'h0040:
  - digit3 and digit2 are blank (8'hFF), digit1=8'h99, digit0=8'hC0.
  - Loading 16'h0000 shows only digit0=8'hC0.
